plic_target: RTL
================

Name: plic_target

Overview:
- Per-target (hart context) side of the PLIC claim/complete protocol; one instance per target.
- Sweeps the source pending vector sequentially and selects the highest-priority enabled pending source above the target threshold.
- Drives the target's external-interrupt line.
- Converts register-level claim reads and complete writes into the claim/complete broadcast consumed by every source gateway.

Parameters:
- N_SRC, 31, number of sources (1..31); source IDs 1..N_SRC, ID 0 = "no interrupt".
- PRIO_W, 3, priority width in bits; priority 0 never interrupts.
- TGT_ID, 0, this target's ID (0..31), driven on claim_tgt/complete_tgt.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- int_pending  in  N_SRC  gateway pending flags; bit k = source k+1
- src_prio  in  N_SRC*PRIO_W  source priorities, flattened; slice k = source k+1
- src_en  in  N_SRC  this target's enable bits; bit k = source k+1
- threshold  in  PRIO_W  this target's priority threshold
- eip  out  1  external interrupt to target
- claim_req  in  1  claim read request; level, held until claim_ack
- claim_ack  out  1  one-cycle pulse; claim_id valid this cycle
- claim_id  out  5  claimed source ID (0 if none)
- complete_req  in  1  complete write request; level, held until complete_ack
- complete_id  in  5  source ID written
- complete_ack  out  1  one-cycle pulse
- claim_valid / claim_src / claim_tgt  out  1/5/5  claim broadcast to gateways
- complete_valid / complete_src / complete_tgt  out  1/5/5  complete broadcast to gateways

Behaviour:
- Reset: all outputs 0; idx=1, best_id=0, best_prio=0, cur_id=0, cur_prio=0, result_valid=0.
- Sweep, one source per cycle at idx:
  - Candidate if int_pending, src_en and prio>best_prio (strict), so lowest ID wins ties.
  - At idx==N_SRC: commit the running best (including that cycle's candidate) to cur_id/cur_prio, set result_valid, reset running best, idx wraps to 1.
  - Sweep period = N_SRC cycles; first commit on cycle N_SRC after reset release.
- eip (registered) = result_valid & (cur_id!=0) & (cur_prio>threshold).
  - threshold is compared at use, not latched at commit.
- Claim:
  - In a cycle with claim_req & result_valid & ~claim_ack, latch the response.
  - Next cycle: claim_ack=1, claim_id = eip-condition ? cur_id : 0.
  - Same cycle as claim_ack: claim_valid=1 only if claim_id!=0, with claim_src=claim_id and claim_tgt=TGT_ID.
  - Response latch also clears result_valid and eip, and restarts the sweep at idx=1 with the running best cleared, so a stale winner is never claimed twice.
  - claim_req while result_valid=0 waits with no ack until the next commit.
- Complete:
  - In a cycle with complete_req & ~complete_ack, latch complete_id.
  - Next cycle: complete_ack=1.
  - Same cycle: complete_valid=1 iff 1<=id<=N_SRC, with complete_src=id and complete_tgt=TGT_ID.
  - Out-of-range or 0 IDs are acked silently. Completes do not disturb the sweep.
- Simultaneous claim and complete: served independently in the same cycle; both broadcasts may be valid together.
- Back-to-back requests: a held req after ack needs a fresh accept cycle. Max one claim per commit; max one complete per 2 cycles.
- Reset mid-sweep or mid-handshake: state returns to reset values immediately; pending acks are dropped.
- claim_src/complete_src/claim_tgt/complete_tgt hold their last value when the matching valid is 0.

Optional Feature:
- PLIC_TARGET_STALE_CHECK_EN.
- Defined: at claim latch, re-check int_pending and src_en of cur_id in that cycle; if either is clear, claim_id=0 and no claim_valid.
- Undefined: committed cur_id is returned unchecked.

Test Plan:
- Reset with rst held 3 cycles, then released → all outputs 0; with src2 enabled, pending and prio 4, threshold 0 (N_SRC=8), eip rises within 9 cycles of release.
- N_SRC=8, TGT_ID=2: src3 and src6 both prio 5, enabled, pending, threshold 2 → eip=1; claim_req → claim_ack, claim_id=3, claim_valid with src 3, tgt 2; eip drops the cycle after the accept cycle.
- Same setup, threshold 5 → eip=0; claim returns claim_id=0 with no claim_valid. src6 prio 7 → next claim returns 6.
- complete_req with complete_id=3 → ack next cycle, complete_valid src 3, tgt 2. complete_id=0 and complete_id=9 → ack only, no complete_valid.
- claim_req and complete_req (id 6) asserted in the same cycle with a valid result → claim_ack and complete_ack in the same cycle, both broadcasts valid.
- claim_req asserted right after reset release → no ack until the first commit, then ack the next cycle. With the macro defined, drop src3 pending the cycle before accept → claim_id=0.

Source files
------------

// File: rtl/plic_target.sv
// PLIC target context: sequential priority sweep, eip, and claim/complete to gateway broadcast.
// Optional PLIC_TARGET_STALE_CHECK_EN re-validates the committed winner when a claim is latched.
module plic_target #(
    parameter int N_SRC  = 31,
    parameter int PRIO_W = 3,
    parameter int TGT_ID = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        int_pending,
    input  logic [N_SRC*PRIO_W-1:0] src_prio,
    input  logic [N_SRC-1:0]        src_en,
    input  logic [PRIO_W-1:0]       threshold,
    output logic                    eip,
    input  logic                    claim_req,
    output logic                    claim_ack,
    output logic [4:0]              claim_id,
    input  logic                    complete_req,
    input  logic [4:0]              complete_id,
    output logic                    complete_ack,
    output logic                    claim_valid,
    output logic [4:0]              claim_src,
    output logic [4:0]              claim_tgt,
    output logic                    complete_valid,
    output logic [4:0]              complete_src,
    output logic [4:0]              complete_tgt
);
    localparam logic [4:0] LAST_ID = 5'(N_SRC);
    localparam logic [4:0] TGT     = 5'(TGT_ID);

    logic [4:0]        idx;
    logic [4:0]        best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [4:0]        cur_id;
    logic [PRIO_W-1:0] cur_prio;
    logic              result_valid;

    logic              sel_pend;
    logic              sel_en;
    logic [PRIO_W-1:0] sel_prio;
    logic              cand;
    logic [4:0]        nxt_id;
    logic [PRIO_W-1:0] nxt_prio;
    logic              win;
    logic              claim_acc;
    logic              cmp_acc;
    logic              cmp_ok;

    always_comb begin
        sel_pend = 1'b0;
        sel_en   = 1'b0;
        sel_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx == 5'(i + 1)) begin
                sel_pend = int_pending[i];
                sel_en   = src_en[i];
                sel_prio = src_prio[i*PRIO_W +: PRIO_W];
            end
        end
        // Strict compare: on equal priority the lower ID, seen first, is kept.
        cand     = sel_pend & sel_en & (sel_prio > best_prio);
        nxt_id   = cand ? idx : best_id;
        nxt_prio = cand ? sel_prio : best_prio;
    end

`ifdef PLIC_TARGET_STALE_CHECK_EN
    logic cur_live;
    always_comb begin
        cur_live = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_id == 5'(i + 1))
                cur_live = int_pending[i] & src_en[i];
        end
        win = (cur_id != 5'd0) & (cur_prio > threshold) & cur_live;
    end
`else
    assign win = (cur_id != 5'd0) & (cur_prio > threshold);
`endif

    assign claim_acc = claim_req & result_valid & ~claim_ack;
    assign cmp_acc   = complete_req & ~complete_ack;
    assign cmp_ok    = (complete_id != 5'd0) && ({1'b0, complete_id} <= 6'(N_SRC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= 5'd1;
            best_id      <= '0;
            best_prio    <= '0;
            cur_id       <= '0;
            cur_prio     <= '0;
            result_valid <= 1'b0;
            eip          <= 1'b0;
        end else if (claim_acc) begin
            // Restart the sweep so the winner just handed out is never claimed twice.
            idx          <= 5'd1;
            best_id      <= '0;
            best_prio    <= '0;
            result_valid <= 1'b0;
            eip          <= 1'b0;
        end else begin
            eip <= result_valid & (cur_id != 5'd0) & (cur_prio > threshold);
            if (idx == LAST_ID) begin
                cur_id       <= nxt_id;
                cur_prio     <= nxt_prio;
                result_valid <= 1'b1;
                best_id      <= '0;
                best_prio    <= '0;
                idx          <= 5'd1;
            end else begin
                best_id   <= nxt_id;
                best_prio <= nxt_prio;
                idx       <= idx + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            claim_ack   <= 1'b0;
            claim_id    <= '0;
            claim_valid <= 1'b0;
            claim_src   <= '0;
            claim_tgt   <= '0;
        end else begin
            claim_ack   <= claim_acc;
            claim_id    <= (claim_acc & win) ? cur_id : 5'd0;
            claim_valid <= claim_acc & win;
            if (claim_acc & win) begin
                claim_src <= cur_id;
                claim_tgt <= TGT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complete_ack   <= 1'b0;
            complete_valid <= 1'b0;
            complete_src   <= '0;
            complete_tgt   <= '0;
        end else begin
            complete_ack   <= cmp_acc;
            complete_valid <= cmp_acc & cmp_ok;
            if (cmp_acc & cmp_ok) begin
                complete_src <= complete_id;
                complete_tgt <= TGT;
            end
        end
    end
endmodule
